// File: rtl/sb_stream_arbiter.sv
// Packet-aware N:1 round-robin arbiter for switchboard streams.
// A winner keeps the grant until its last beat is accepted. A one-entry
// registered output stage feeds the shared sink at one beat per cycle.
module sb_stream_arbiter #(
    parameter int N  = 4,
    parameter int DW = 256,
    parameter int IW = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [N-1:0]      en,
    input  logic [N*DW-1:0]   in_data,
    input  logic [N*32-1:0]   in_dest,
    input  logic [N-1:0]      in_last,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [DW-1:0]     out_data,
    output logic [31:0]       out_dest,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [IW-1:0]     owner
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [DW-1:0]   data_q, data_d;
    logic [31:0]     dest_q, dest_d;
    logic            last_q, last_d;
    logic            valid_q, valid_d;

    logic [DW-1:0]   lane_data [N];
    logic [31:0]     lane_dest [N];

    logic            rr_found;
    logic [IW-1:0]   rr_win;
    logic [IW-1:0]   sel;
    logic            sel_ok;
    logic            slot_free;
    logic            grant;
    logic            accept;

    // Split the flat requester buses into per-lane views.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign lane_data[gi] = in_data[gi*DW +: DW];
        assign lane_dest[gi] = in_dest[gi*32 +: 32];
    end

    // Pointer advance with explicit wrap so non-power-of-two N works.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        if (int'(p) == N - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = p + IW'(1);
        end
    endfunction

    // Round-robin search: first enabled, valid requester at or after ptr.
    // Iterating from the farthest offset down lets the nearest one win last.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int k;
            k = int'(ptr_q) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (in_valid[k] && en[k]) begin
                rr_found = 1'b1;
                rr_win   = IW'(k);
            end
        end
    end

    // Grant selection, handshake and next-state logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        data_d   = data_q;
        dest_d   = dest_q;
        last_d   = last_q;
        valid_d  = valid_q;
        in_ready = '0;

        // A locked packet keeps its owner even if its enable drops.
        sel       = (state_q == ST_LOCKED) ? owner_q : rr_win;
        sel_ok    = (state_q == ST_LOCKED) ? 1'b1 : rr_found;
        slot_free = !valid_q || out_ready;
        grant     = sel_ok && slot_free && nreset;
        accept    = grant && in_valid[sel];

        if (grant) begin
            in_ready[sel] = 1'b1;
        end

        if (accept) begin
            data_d  = lane_data[sel];
            dest_d  = lane_dest[sel];
            last_d  = in_last[sel];
            valid_d = 1'b1;
            if (state_q == ST_IDLE) begin
                owner_d = sel;
            end
            if (in_last[sel]) begin
                state_d = ST_IDLE;
                ptr_d   = next_ptr(sel);
            end else begin
                state_d = ST_LOCKED;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output-stage registers; reset drops any lock and buffered beat.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            dest_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_dest  = dest_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == ST_LOCKED);
    assign owner     = owner_q;

endmodule

// File: tb/tb_sb_stream_arbiter.sv
// Directed bench for sb_stream_arbiter: per-requester beat queues drive the
// inputs, an expected-order scoreboard is checked against the output port.
module tb_sb_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   dest;
        logic          last;
    } beat_t;

    logic              clk;
    logic              nreset;
    logic [N-1:0]      en;
    logic [N*DW-1:0]   in_data;
    logic [N*32-1:0]   in_dest;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [DW-1:0]     out_data;
    logic [31:0]       out_dest;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [IW-1:0]     owner;

    sb_stream_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .en        (en),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t rq [N][$];
    beat_t sb [$];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    logic          s_nreset, s_out_valid, s_out_ready, s_out_last, s_busy;
    logic [N-1:0]  s_in_valid, s_in_ready;
    logic [DW-1:0] s_out_data;
    logic [31:0]   s_out_dest;
    logic [IW-1:0] s_owner;
    logic          p_stall;
    beat_t         p_beat;

    function automatic beat_t mk(int k, int s, bit last);
        beat_t b;
        b.data = DW'((k << 8) | s);
        b.dest = 32'hD000_0000 | 32'((k << 8) | s);
        b.last = last;
        return b;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(int k, int s, bit last);
        rq[k].push_back(mk(k, s, last));
    endtask

    task automatic expect_beat(int k, int s, bit last);
        sb.push_back(mk(k, s, last));
    endtask

    // One clock: drive queue heads, sample mid-cycle, then resolve handshakes.
    task automatic cycle();
        beat_t b;
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() > 0) begin
                b = rq[k][0];
                in_valid[k] = 1'b1;
                in_last[k]  = b.last;
                in_data[k*DW +: DW] = b.data;
                in_dest[k*32 +: 32] = b.dest;
            end else begin
                in_valid[k] = 1'b0;
                in_last[k]  = 1'b0;
                in_data[k*DW +: DW] = '0;
                in_dest[k*32 +: 32] = '0;
            end
        end
        #1;
        s_nreset    = nreset;
        s_in_valid  = in_valid;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_ready = out_ready;
        s_out_data  = out_data;
        s_out_dest  = out_dest;
        s_out_last  = out_last;
        s_busy      = busy;
        s_owner     = owner;

        if (s_nreset) begin
            check("in_ready_onehot", 64'($onehot0(s_in_ready)), 64'd1);
            if (p_stall) begin
                check("stall_hold", {s_out_valid, s_out_data, s_out_dest, s_out_last},
                      {1'b1, p_beat});
            end
            if (s_busy === 1'b1) busy_cnt++;
        end
        p_stall = s_nreset && (s_out_valid === 1'b1) && !s_out_ready;
        p_beat  = {s_out_data, s_out_dest, s_out_last};

        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (s_in_ready[k] && s_in_valid[k]) void'(rq[k].pop_front());
        end
        if (s_nreset && s_out_valid && s_out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_beat", {s_out_data, s_out_dest, s_out_last}, 64'd0);
            end else begin
                b = sb.pop_front();
                $display("beat data=%04h dest=%08h last=%0b expected data=%04h",
                         s_out_data, s_out_dest, s_out_last, b.data);
                check("beat", {s_out_data, s_out_dest, s_out_last}, b);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(string tag, int budget, output int n);
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n;
    int total;
    bit had;
    logic [3:0] pat [7];

    initial begin
        nreset = 1'b0; en = 4'hF; out_ready = 1'b1;
        in_data = '0; in_dest = '0; in_last = '0; in_valid = '0;
        p_stall = 1'b0; p_beat = '0;
        @(negedge clk);

        // Reset with every requester valid, then round-robin single beats.
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < N; k++) begin
                load(k, s, 1'b1);
                expect_beat(k, s, 1'b1);
            end
        end
        cycle();
        cycle();
        check("rst_in_ready", s_in_ready, 0);
        check("rst_out_valid", s_out_valid, 0);
        check("rst_out_data", s_out_data, 0);
        check("rst_out_dest", s_out_dest, 0);
        check("rst_out_last", s_out_last, 0);
        check("rst_busy", s_busy, 0);
        check("rst_owner", s_owner, 0);
        nreset = 1'b1;
        cycle();
        check("first_grant", s_in_ready, 4'b0001);
        check("first_out_valid", s_out_valid, 0);
        drain("rr_drain", 30, n);
        total = n + 1;
        check("rr_throughput_cycles", total, 9);
        cycle();
        check("rr_owner", s_owner, 3);

        // Three-beat packet from requester 1 with requester 2 waiting.
        busy_cnt = 0;
        load(1, 0, 1'b0); load(1, 1, 1'b0); load(1, 2, 1'b1);
        load(2, 0, 1'b1);
        expect_beat(1, 0, 1'b0); expect_beat(1, 1, 1'b0); expect_beat(1, 2, 1'b1);
        expect_beat(2, 0, 1'b1);
        drain("pkt_drain", 30, n);
        check("pkt_cycles", n, 5);
        check("pkt_busy_cycles", busy_cnt, 2);
        check("pkt_owner", s_owner, 2);

        // Output stalls in the middle of a four-beat packet from requester 0.
        pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0; pat[4] = 1; pat[5] = 1; pat[6] = 1;
        for (int s = 0; s < 4; s++) begin
            load(0, s, s == 3);
            expect_beat(0, s, s == 3);
        end
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            had = rq[0].size() > 0;
            cycle();
            check("stall_in_ready", s_in_ready,
                  (had && (!s_out_valid || s_out_ready)) ? 4'b0001 : 4'b0000);
        end
        out_ready = 1'b1;
        drain("stall_drain", 10, n);

        // Masked requesters: only 1 and 3 may be granted.
        en = 4'b1010;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < N; k++) load(k, s, 1'b1);
            expect_beat(1, s, 1'b1);
            expect_beat(3, s, 1'b1);
        end
        drain("mask_drain", 20, n);
        check("mask_r0_untouched", rq[0].size(), 2);
        check("mask_r2_untouched", rq[2].size(), 2);
        load(1, 2, 1'b0); load(1, 3, 1'b0); load(1, 4, 1'b1);
        load(3, 2, 1'b1);
        expect_beat(1, 2, 1'b0); expect_beat(1, 3, 1'b0); expect_beat(1, 4, 1'b1);
        expect_beat(3, 2, 1'b1);
        cycle();
        en = 4'b1000;
        drain("en_drop_drain", 20, n);
        en = 4'hF;
        expect_beat(0, 0, 1'b1); expect_beat(2, 0, 1'b1);
        expect_beat(0, 1, 1'b1); expect_beat(2, 1, 1'b1);
        drain("unmask_drain", 20, n);

        // Reset while requester 3 holds a packet with a beat buffered.
        load(3, 3, 1'b0); load(3, 4, 1'b0); load(3, 5, 1'b0); load(3, 6, 1'b1);
        load(0, 2, 1'b1);
        expect_beat(3, 3, 1'b0);
        cycle();
        cycle();
        check("mid_busy", s_busy, 1);
        nreset = 1'b0;
        out_ready = 1'b0;
        rq[3].delete();
        cycle();
        check("mid_rst_in_ready", s_in_ready, 0);
        nreset = 1'b1;
        out_ready = 1'b1;
        expect_beat(0, 2, 1'b1);
        cycle();
        check("post_rst_busy", s_busy, 0);
        check("post_rst_out_valid", s_out_valid, 0);
        check("post_rst_grant", s_in_ready, 4'b0001);
        drain("post_rst_drain", 10, n);
        for (int i = 0; i < 3; i++) cycle();
        check("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_stream_arbiter.md
# sb_stream_arbiter

Packet-aware N:1 round-robin arbiter that shares a single switchboard stream output (data/dest/last/valid/ready) among N switchboard stream requesters. Once a requester wins, its grant is held until its `last` beat is accepted, so packets are never interleaved. A one-entry registered output stage decouples the shared sink from the requesters while sustaining one beat per cycle. It sits between several packet sources (e.g. per-channel modifiers) and one `SB_TO_QUEUE_SIM` TX port.

## Interface
Parameters:
- `N`, default 4: number of requesters, ≥2.
- `DW`, default 256: data width per beat.
- `IW`, default 2: grant index width, `$clog2(N)`.

Ports:
- `clk`  input  1  sole clock; everything is on posedge.
- `nreset`  input  1  synchronous, active-low reset.
- `en`  input  N  per-requester enable mask; a disabled requester is never newly granted.
- `in_data`  input  N*DW  requester k occupies `[k*DW +: DW]`.
- `in_dest`  input  N*32  requester k occupies `[k*32 +: 32]`.
- `in_last`  input  N  end-of-packet flag per requester.
- `in_valid`  input  N  beat valid per requester.
- `in_ready`  output  N  beat accepted per requester; at most one bit is high.
- `out_data`  output  DW  registered shared output.
- `out_dest`  output  32  registered shared output.
- `out_last`  output  1  registered shared output.
- `out_valid`  output  1  registered shared output.
- `out_ready`  input  1  sink ready.
- `busy`  output  1  high while a multi-beat packet is locked.
- `owner`  output  IW  index of the current or most recent grant.

## Operation
- Output slot is free when `!out_valid || out_ready`.
- States: IDLE and LOCKED(owner).
- IDLE:
  - Winner is the first k, searching from `ptr` upward modulo N, with `in_valid[k] && en[k]`.
  - `in_ready[winner] = slot_free`, combinational; no cycle is lost to arbitration.
  - Accepted beat with `last=1`: stay IDLE and set `ptr <= winner+1 mod N`.
  - Accepted beat with `last=0`: go to LOCKED(winner) and set `owner <= winner`.
- LOCKED(o):
  - `in_ready[o] = slot_free`; all other `in_ready` bits are 0 regardless of their valid.
  - `en[o]` deasserting does not abort the packet; it completes.
  - Accepted beat with `last=1`: go to IDLE and set `ptr <= o+1 mod N`.
- On any accept, `out_data/out_dest/out_last` load the selected requester's fields and `out_valid <= 1`.
- If `out_ready` is high with no accept, `out_valid <= 0`; data fields hold their last value.
- `in_valid` without `in_ready` must be held stable by the requester (switchboard rule). The arbiter does not re-arbitrate inside a packet.
- `busy` = state is LOCKED. `owner` updates on every first-beat accept.
- No requester valid, or all disabled: no grant, `ptr` unchanged.

## Timing
- Reset (`nreset`=0 at posedge):
  - IDLE, `ptr=0`.
  - `out_valid=0`, `out_data=0`, `out_dest=0`, `out_last=0`.
  - `busy=0`, `owner=0`.
  - `in_ready` all 0 during reset.
- Reset mid-packet discards the lock and the buffered beat. No partial state survives.
- Latency: a beat accepted at edge t appears on `out_*` after edge t, i.e. 1 cycle.
- Throughput: one beat per cycle with `out_ready` held high, including back-to-back packets from different requesters. Switching owner costs zero bubbles.
- `out_ready=0` with `out_valid=1`: outputs are frozen and all `in_ready` are 0.
- `ptr` wraps from N-1 to 0.
- Single-beat packets never enter LOCKED.
- Simultaneous first beats: only the round-robin winner is accepted; the others wait.

## Test plan
- Reset with all inputs valid → all outputs 0 and `in_ready=0`. First post-reset cycle: requester 0 is granted, `out_valid` rises one cycle later.
- All 4 requesters stream single-beat packets, `out_ready=1`, `en=4'hF` → grants in order 0,1,2,3,0,… with one beat per cycle on `out_data`.
- Requester 1 sends a 3-beat packet while requester 2 is valid throughout → `out` carries beats 1a,1b,1c contiguously, then 2. `busy` is high for exactly 2 cycles.
- Toggle `out_ready` 1,0,0,1 during a packet → `out_*` hold through the stall, no beat is lost or duplicated, and `in_ready` mirrors the slot-free condition.
- `en=4'b1010` with all valid → only requesters 1 and 3 are granted, alternating. Clearing `en[1]` mid-packet still completes that packet.
- Assert `nreset=0` mid-packet of requester 3 → next grant is requester 0, `busy=0`, and no stale beat is emitted.
